// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter that shares one 10-bit XNOR LFSR among NREQ requesters, one value per draw.
// Optional feature macro LFSR_RANGE_LIMIT_EN adds the limit port and rejection resampling (CHECK state).
module lfsr_rand_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned STEPS = 4
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
`ifdef LFSR_RANGE_LIMIT_EN
  input  logic [9:0]      limit,
`endif
  output logic [NREQ-1:0] grant,
  output logic [9:0]      rand_out,
  output logic            busy
);

  localparam int unsigned LFSR_W = 10;
  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned IDX_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_CHECK   = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [LFSR_W-1:0] lfsr, lfsr_d;
  logic [CNT_W-1:0]  step_cnt, step_cnt_d;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]  owner, owner_d;
  logic [NREQ-1:0]   grant_d;
  logic [LFSR_W-1:0] rand_out_d;
  logic              busy_d;

  logic [PTR_W-1:0]  pick_c;
  logic              pick_valid_c;
  logic [IDX_W-1:0]  idx_c;

  function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[6] ~^ q[9]};
  endfunction

  // First set request at or after the round-robin pointer, wrapping at NREQ.
  always_comb begin
    pick_c       = '0;
    pick_valid_c = 1'b0;
    idx_c        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = {1'b0, rr_ptr} + IDX_W'(i);
      if (idx_c >= IDX_W'(NREQ)) begin
        idx_c = idx_c - IDX_W'(NREQ);
      end
      if (!pick_valid_c && req[idx_c[PTR_W-1:0]]) begin
        pick_c       = idx_c[PTR_W-1:0];
        pick_valid_c = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    lfsr_d     = lfsr;
    step_cnt_d = step_cnt;
    rr_ptr_d   = rr_ptr;
    owner_d    = owner;
    grant_d    = '0;
    rand_out_d = rand_out;
    busy_d     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (pick_valid_c) begin
          owner_d    = pick_c;
          step_cnt_d = '0;
          state_d    = S_STEP;
        end
      end

      S_STEP: begin
        lfsr_d = lfsr_shift(lfsr);
        if (step_cnt == LAST_STEP) begin
          step_cnt_d = '0;
`ifdef LFSR_RANGE_LIMIT_EN
          state_d    = S_CHECK;
`else
          state_d    = S_DELIVER;
`endif
        end else begin
          step_cnt_d = step_cnt + 1'b1;
        end
      end

`ifdef LFSR_RANGE_LIMIT_EN
      // Out-of-range values are discarded and a fresh run of STEPS shifts is drawn.
      S_CHECK: begin
        step_cnt_d = '0;
        state_d    = (lfsr <= limit) ? S_DELIVER : S_STEP;
      end
`endif

      S_DELIVER: begin
        rr_ptr_d = (owner == LAST_REQ) ? '0 : owner + 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Registered outputs describe the state being entered, so grant lines up with DELIVER.
    busy_d = (state_d == S_STEP) || (state_d == S_CHECK);
    if (state_d == S_DELIVER) begin
      grant_d[owner_d] = 1'b1;
      rand_out_d       = lfsr_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state    <= S_IDLE;
      lfsr     <= '0;
      step_cnt <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
      grant    <= '0;
      rand_out <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      lfsr     <= lfsr_d;
      step_cnt <= step_cnt_d;
      rr_ptr   <= rr_ptr_d;
      owner    <= owner_d;
      grant    <= grant_d;
      rand_out <= rand_out_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Directed bench for lfsr_rand_arbiter: LFSR values, round-robin order, latency, reset abort.
// Build with LFSR_RANGE_LIMIT_EN defined to also exercise the range-limit retry path.
module tb_lfsr_rand_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned STEPS = 4;
`ifdef LFSR_RANGE_LIMIT_EN
  localparam int LAT = STEPS + 2;
`else
  localparam int LAT = STEPS + 1;
`endif
  localparam int GAP = LAT + 1;

  logic            Clock = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req   = '0;
  logic [NREQ-1:0] grant;
  logic [9:0]      rand_out;
  logic            busy;
`ifdef LFSR_RANGE_LIMIT_EN
  logic [9:0]      limit = 10'h3FF;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  lfsr_rand_arbiter #(.NREQ(NREQ), .STEPS(STEPS)) dut (
    .Clock    (Clock),
    .reset    (reset),
    .req      (req),
`ifdef LFSR_RANGE_LIMIT_EN
    .limit    (limit),
`endif
    .grant    (grant),
    .rand_out (rand_out),
    .busy     (busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grants must be one-hot and never last more than one cycle.
  logic [NREQ-1:0] prev_grant = '0;
  always @(negedge Clock) begin
    if (grant != '0) begin
      check("grant_onehot", 32'($countones(grant)), 32'd1);
      check("grant_pulse", 32'(prev_grant), 32'd0);
    end
    prev_grant = grant;
  end

  task automatic wait_grant(input int maxc, output logic [NREQ-1:0] g,
                            output logic [9:0] r, output int c);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (grant == '0 && n < maxc);
    g = grant;
    r = rand_out;
    c = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge Clock);
    reset = 1'b0;
  endtask

  logic [NREQ-1:0] exp_ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NREQ-1:0] g;
  logic [9:0]      r;
  int              c, c0;

  initial begin
    // Reset state
    repeat (2) @(negedge Clock);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rand", 32'(rand_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Single requester held: three back-to-back draws
    req = 4'b0001;
    c0  = cyc;
    wait_grant(50, g, r, c);
    check("t1_d1_grant", 32'(g), 32'h1);
    check("t1_d1_rand", 32'(r), 32'h00F);
    check("t1_d1_lat", 32'(c - c0), 32'(LAT));
    c0 = c;
    wait_grant(50, g, r, c);
    check("t1_d2_grant", 32'(g), 32'h1);
    check("t1_d2_rand", 32'(r), 32'h0FE);
    check("t1_d2_gap", 32'(c - c0), 32'(GAP));
    c0 = c;
    wait_grant(50, g, r, c);
    check("t1_d3_grant", 32'(g), 32'h1);
    check("t1_d3_rand", 32'(r), 32'h3E3);
    check("t1_d3_gap", 32'(c - c0), 32'(GAP));
    req = '0;
    repeat (3) @(negedge Clock);
    check("t1_hold_rand", 32'(rand_out), 32'h3E3);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // All requesters held: strict rotation
    do_reset();
    req = '1;
    c0  = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_grant(50, g, r, c);
      check($sformatf("t2_order%0d", i), 32'(g), 32'(exp_ord[i]));
      if (i > 0) check($sformatf("t2_gap%0d", i), 32'(c - c0), 32'(GAP));
      c0 = c;
    end
    req = '0;
    repeat (3) @(negedge Clock);

    // One-cycle request still served; pointer then favours req[3]
    do_reset();
    req = 4'b0100;
    c0  = cyc;
    @(negedge Clock);
    req = '0;
    wait_grant(50, g, r, c);
    check("t3_grant", 32'(g), 32'b0100);
    check("t3_lat", 32'(c - c0), 32'(LAT));
    req = 4'b1001;
    wait_grant(50, g, r, c);
    check("t3_next", 32'(g), 32'b1000);
    check("t3_next_rand", 32'(r), 32'h0FE);
    req = '0;
    @(negedge Clock);

    // Reset during STEP aborts the draw
    req = 4'b0001;
    repeat (2) @(negedge Clock);
    check("t4_busy_step", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge Clock);
    check("t4_rst_grant", 32'(grant), 32'd0);
    check("t4_rst_rand", 32'(rand_out), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    c0 = cyc;
    wait_grant(50, g, r, c);
    check("t4_grant", 32'(g), 32'h1);
    check("t4_rand", 32'(r), 32'h00F);
    check("t4_lat", 32'(c - c0), 32'(LAT));
    req = '0;
    repeat (2) @(negedge Clock);

`ifdef LFSR_RANGE_LIMIT_EN
    // Range limit: third raw value is rejected and resampled
    do_reset();
    limit = 10'h0FF;
    req   = 4'b0001;
    wait_grant(50, g, r, c);
    check("t5_d1_rand", 32'(r), 32'h00F);
    wait_grant(50, g, r, c);
    check("t5_d2_rand", 32'(r), 32'h0FE);
    c0 = c + 1;
    wait_grant(400, g, r, c);
    check("t5_d3_grant", 32'(g), 32'h1);
    check("t5_d3_range", 32'(r <= 10'h0FF), 32'd1);
    check("t5_d3_slow", 32'((c - c0) >= int'(2 * STEPS + 2)), 32'd1);
    req = '0;
    repeat (2) @(negedge Clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
